// File: rtl/bsg_fifo_rr_enq_ctrl_if.sv
// Handshake and status bundle between producers/consumer and the round-robin
// FIFO enqueue controller.
interface bsg_fifo_rr_enq_ctrl_if #(
  parameter int els_p     = 1024,
  parameter int num_req_p = 4
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p) + 1;
  localparam int id_w  = $clog2(num_req_p);

  // Handshake: producer i holds v_i[i] until it sees ready_o[i] high in the
  // same cycle; a transfer happens on that edge and nothing is queued by the
  // controller otherwise. The consumer pulses yumi_i; it only takes effect
  // when deq_o is high in that cycle.
  logic [num_req_p-1:0] v_i;
  logic [num_req_p-1:0] ready_o;
  logic [id_w-1:0]      grant_id_o;
  logic                 enq_o;
  logic                 yumi_i;
  logic                 deq_o;
  logic [ptr_w-1:0]     wptr_r_o;
  logic [ptr_w-1:0]     rptr_r_o;
  logic [cnt_w-1:0]     count_r_o;
  logic                 full_o;
  logic                 empty_o;
  logic                 err_o;
  logic [id_w-1:0]      last_r_o;  // round-robin priority pointer, debug view

  modport master (
    output v_i, yumi_i,
    input  ready_o, grant_id_o, enq_o, deq_o, wptr_r_o, rptr_r_o,
           count_r_o, full_o, empty_o, err_o, last_r_o
  );

  modport slave (
    input  v_i, yumi_i,
    output ready_o, grant_id_o, enq_o, deq_o, wptr_r_o, rptr_r_o,
           count_r_o, full_o, empty_o, err_o, last_r_o
  );
endinterface

// File: rtl/bsg_fifo_rr_enq_ctrl.sv
// FIFO pointer/occupancy controller with a round-robin arbiter choosing one
// of several producers per cycle; storage lives outside this block.
module bsg_fifo_rr_enq_ctrl #(
  parameter int els_p     = 1024,
  parameter int num_req_p = 4
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bsg_fifo_rr_enq_ctrl_if.slave  bus
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p) + 1;
  localparam int id_w  = $clog2(num_req_p);
  localparam logic [cnt_w-1:0] els_lp = cnt_w'(els_p);

  logic [ptr_w-1:0] wptr_q, wptr_d;
  logic [ptr_w-1:0] rptr_q, rptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic [id_w-1:0]  last_q, last_d;
  logic             err_q, err_d;

  logic [num_req_p-1:0] ready;
  logic [id_w-1:0]      grant_id;
  logic                 found;
  logic                 full, empty, enq, deq;
  int                   idx;

  assign full  = (count_q == els_lp);
  assign empty = (count_q == '0);

  // Search starts one past the last winner and wraps; full blocks all grants
  // even if a dequeue lands in the same cycle.
  always_comb begin
    ready    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= num_req_p; k++) begin
      idx = (int'(last_q) + k) % num_req_p;
      if (!found && bus.v_i[idx] && !full && !reset_i) begin
        ready[idx] = 1'b1;
        grant_id   = id_w'(idx);
        found      = 1'b1;
      end
    end
  end

  assign enq = |ready;
  assign deq = bus.yumi_i & ~empty & ~reset_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    last_d  = last_q;
    err_d   = err_q;
    if (enq) begin
      wptr_d = wptr_q + ptr_w'(1);
      last_d = grant_id;
    end
    if (deq) rptr_d = rptr_q + ptr_w'(1);
    if (enq && !deq) count_d = count_q + cnt_w'(1);
    if (deq && !enq) count_d = count_q - cnt_w'(1);
    if (bus.yumi_i && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      last_q  <= id_w'(num_req_p - 1);
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready_o    = ready;
  assign bus.grant_id_o = grant_id;
  assign bus.enq_o      = enq;
  assign bus.deq_o      = deq;
  assign bus.wptr_r_o   = wptr_q;
  assign bus.rptr_r_o   = rptr_q;
  assign bus.count_r_o  = count_q;
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.err_o      = err_q;
  assign bus.last_r_o   = last_q;
endmodule

// File: tb/tb_bsg_fifo_rr_enq_ctrl.sv
// Bench for bsg_fifo_rr_enq_ctrl: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_bsg_fifo_rr_enq_ctrl;
  localparam int ELS = 1024;
  localparam int NR  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bsg_fifo_rr_enq_ctrl_if #(.els_p(ELS), .num_req_p(NR)) bus ();

  bsg_fifo_rr_enq_ctrl #(.els_p(ELS), .num_req_p(NR)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the FIFO contents as a queue of producer ids plus
  // running totals of enqueues and dequeues.
  int mq[$];
  int m_wr, m_rd, m_last;
  bit m_err;

  typedef struct {
    logic [NR-1:0] v;
    logic          y;
    logic [NR-1:0] exp_ready;
    logic          exp_deq;
    int            exp_count;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void arb(input logic [NR-1:0] v, input int last, input bit full,
                              output logic [NR-1:0] rdy, output int id);
    rdy = '0;
    id  = 0;
    if (!full) begin
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (last + k) % NR;
        if (v[i]) begin
          rdy[i] = 1'b1;
          id = i;
          break;
        end
      end
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wr = 0;
    m_rd = 0;
    m_last = NR - 1;
    m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.v_i = '1;
    bus.yumi_i = 1'b1;
    #1;
    chk("rst_ready", bus.ready_o, 0);
    chk("rst_enq", bus.enq_o, 0);
    chk("rst_deq", bus.deq_o, 0);
    chk("rst_count", bus.count_r_o, 0);
    chk("rst_wptr", bus.wptr_r_o, 0);
    chk("rst_rptr", bus.rptr_r_o, 0);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_full", bus.full_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_last", bus.last_r_o, NR - 1);
    @(negedge clk);
    reset = 1'b0;
    bus.v_i = '0;
    bus.yumi_i = 1'b0;
    model_reset();
  endtask

  // Drive one cycle at the falling edge, compare everything against the
  // model, then advance the model to what the next rising edge should do.
  task automatic cycle(input logic [NR-1:0] v, input logic y);
    logic [NR-1:0] er;
    int eid;
    bit full, empty;
    @(negedge clk);
    bus.v_i = v;
    bus.yumi_i = y;
    #1;
    full  = (mq.size() == ELS);
    empty = (mq.size() == 0);
    arb(v, m_last, full, er, eid);
    chk("ready", bus.ready_o, er);
    chk("enq", bus.enq_o, |er);
    if (|er) chk("grant_id", bus.grant_id_o, eid);
    chk("deq", bus.deq_o, y && !empty);
    chk("count", bus.count_r_o, mq.size());
    chk("wptr", bus.wptr_r_o, m_wr % ELS);
    chk("rptr", bus.rptr_r_o, m_rd % ELS);
    chk("full", bus.full_o, full);
    chk("empty", bus.empty_o, empty);
    chk("err", bus.err_o, m_err);
    chk("last", bus.last_r_o, m_last);
    if (y && empty) m_err = 1;
    if (y && !empty) begin
      void'(mq.pop_front());
      m_rd++;
    end
    if (|er) begin
      mq.push_back(eid);
      m_wr++;
      m_last = eid;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.v_i = '0;
    bus.yumi_i = 1'b0;
    model_reset();

    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b0, 0};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b0, 1};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b0, 2};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b0, 3};
    tbl[4]  = '{4'b0010, 1'b0, 4'b0010, 1'b0, 4};
    tbl[5]  = '{4'b1010, 1'b0, 4'b1000, 1'b0, 5};
    tbl[6]  = '{4'b1010, 1'b0, 4'b0010, 1'b0, 6};
    tbl[7]  = '{4'b1010, 1'b0, 4'b1000, 1'b0, 7};
    tbl[8]  = '{4'b1010, 1'b0, 4'b0010, 1'b0, 8};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 9};
    tbl[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, tbl[i].y);
      chk($sformatf("tbl%0d_ready", i), bus.ready_o, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_deq", i), bus.deq_o, tbl[i].exp_deq);
      chk($sformatf("tbl%0d_count", i), bus.count_r_o, tbl[i].exp_count);
      if (i == 4) chk("tbl_wptr_after4", bus.wptr_r_o, 4);
    end

    // Simultaneous enqueue and dequeue at count 5 keeps occupancy fixed.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b1);
    cycle(4'b0000, 1'b0);
    chk("simul_count", bus.count_r_o, 5);
    chk("simul_wptr", bus.wptr_r_o, 8);
    chk("simul_rptr", bus.rptr_r_o, 3);

    // Underflow is sticky.
    do_reset();
    cycle(4'b0000, 1'b1);
    chk("uflow_deq", bus.deq_o, 0);
    cycle(4'b0000, 1'b0);
    chk("uflow_err", bus.err_o, 1);
    chk("uflow_rptr", bus.rptr_r_o, 0);
    for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0);
    chk("uflow_err_sticky", bus.err_o, 1);

    // Fill to capacity; a dequeue while full still blocks the request.
    do_reset();
    for (int i = 0; i < ELS; i++) cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    chk("full_flag", bus.full_o, 1);
    chk("full_count", bus.count_r_o, ELS);
    chk("full_wptr", bus.wptr_r_o, 0);
    chk("full_ready", bus.ready_o, 0);
    cycle(4'b0001, 1'b1);
    chk("full_deq", bus.deq_o, 1);
    chk("full_enq", bus.enq_o, 0);
    cycle(4'b0000, 1'b0);
    chk("full_after_deq", bus.count_r_o, ELS - 1);

    // Random traffic in phases of varying dequeue pressure.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 600; i++) begin
        logic [NR-1:0] rv;
        logic ry;
        rv = NR'($urandom_range(0, (1 << NR) - 1));
        ry = ($urandom_range(0, 9) < (p * 3)) ? 1'b1 : 1'b0;
        cycle(rv, ry);
      end
    end

    // Asynchronous reset between edges clears occupancy immediately.
    do_reset();
    for (int i = 0; i < 37; i++) cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b0);
    chk("pre_async_count", bus.count_r_o, 37);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", bus.count_r_o, 0);
    chk("async_wptr", bus.wptr_r_o, 0);
    chk("async_rptr", bus.rptr_r_o, 0);
    chk("async_empty", bus.empty_o, 1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(4'b1111, 1'b0);
    chk("post_reset_grant", bus.grant_id_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bsg_fifo_rr_enq_ctrl.md
BSG_FIFO_RR_ENQ_CTRL -- requirements
Module: bsg_fifo_rr_enq_ctrl

Interface
REQ-001 Parameter: els_p, default 1024, FIFO depth; SHALL be a power of two, at least 2.
REQ-002 Parameter: num_req_p, default 4, number of producer requesters; SHALL be at least 2.
REQ-003 Derived widths: ptr_w = log2(els_p) (10 at default); cnt_w = log2(els_p)+1 (11 at default); id_w = log2(num_req_p) (2 at default).
REQ-004 Port: clk_i, input, 1, the single clock; all state SHALL be clocked on the rising edge.
REQ-005 Port: reset_i, input, 1, reset; asynchronous and active-high.
REQ-006 Port: v_i, input, num_req_p, per-producer enqueue request.
REQ-007 Port: ready_o, output, num_req_p, one-hot grant; bit i high means producer i's request is accepted this cycle.
REQ-008 Port: grant_id_o, output, id_w, binary index of the granted producer; selects the write-data mux; value is don't-care when enq_o=0.
REQ-009 Port: enq_o, output, 1, write strobe to FIFO storage this cycle.
REQ-010 Port: yumi_i, input, 1, consumer dequeue strobe.
REQ-011 Port: deq_o, output, 1, a legal dequeue occurs this cycle.
REQ-012 Port: wptr_r_o, output, ptr_w, registered write address.
REQ-013 Port: rptr_r_o, output, ptr_w, registered read address.
REQ-014 Port: count_r_o, output, cnt_w, registered occupancy.
REQ-015 Port: full_o, output, 1, asserted when count_r_o == els_p.
REQ-016 Port: empty_o, output, 1, asserted when count_r_o == 0.
REQ-017 Port: err_o, output, 1, sticky underflow flag.

Function
REQ-018 Priority pointer last_r (id_w bits): the search starts at (last_r+1) mod num_req_p and proceeds upward with wrap; the first requester with v_i set wins.
REQ-019 ready_o SHALL be combinational from v_i, last_r and full_o: exactly one bit is high iff (|v_i) & ~full_o; otherwise all bits are zero.
REQ-020 enq_o = |ready_o; grant_id_o = index of the set ready_o bit.
REQ-021 On an enq_o cycle, last_r SHALL load grant_id_o at the next edge; otherwise last_r SHALL hold.
REQ-022 A full FIFO SHALL grant no request, even if a dequeue occurs in the same cycle (no full-bypass).
REQ-023 deq_o = yumi_i & ~empty_o.
REQ-024 On empty, dequeue SHALL be accepted only from the cycle after the first enqueue (no empty-bypass).
REQ-025 wptr_r_o SHALL increment by 1 on an enq_o edge; rptr_r_o SHALL increment by 1 on a deq_o edge; both wrap from els_p-1 to 0.
REQ-026 count_r_o at the next edge:
  - count+1 when enq_o & ~deq_o
  - count-1 when deq_o & ~enq_o
  - unchanged otherwise, including a simultaneous enq_o and deq_o
REQ-027 count_r_o SHALL never exceed els_p and never go below 0.
REQ-028 Pointer relation: wptr_r_o - rptr_r_o mod els_p == count_r_o mod els_p at all times.
REQ-029 yumi_i & empty_o SHALL set err_o at the next edge; err_o is cleared only by reset.
REQ-030 A request not granted receives no ready_o; the producer SHALL hold v_i, and the block stores no pending request.

Reset
REQ-031 While reset_i is high:
  - wptr_r_o = 0, rptr_r_o = 0, count_r_o = 0
  - empty_o = 1, full_o = 0, err_o = 0
  - last_r = num_req_p-1, so producer 0 has highest priority after reset
REQ-032 While reset_i is high, ready_o, enq_o and deq_o SHALL be forced to 0.
REQ-033 Reset asserted mid-operation SHALL discard all occupancy immediately (asynchronous), independent of clk_i.
REQ-034 After reset deasserts, the first grant is evaluable in the same cycle.

Verification
REQ-035 After reset, v_i=4'b1111 held for 4 cycles with yumi_i=0 -> grant_id_o sequence 0,1,2,3; count_r_o reaches 4; wptr_r_o=4.
REQ-036 v_i=4'b1010 held with last_r=1 -> grants 3,1,3,1; producers 0 and 2 never granted.
REQ-037 1024 enqueues with no dequeue -> full_o=1, count_r_o=1024, wptr_r_o=0 (wrapped), ready_o=0 while v_i is nonzero. Then yumi_i=1 with v_i=4'b0001 in the same cycle -> deq_o=1, enq_o=0, count_r_o=1023.
REQ-038 At count_r_o=5, simultaneous enq_o and deq_o for 3 cycles -> count_r_o stays 5; both pointers advance by 3.
REQ-039 yumi_i=1 while empty -> deq_o=0, rptr_r_o unchanged, err_o=1 next cycle and still 1 after 10 idle cycles.
REQ-040 Assert reset_i between clock edges at count_r_o=37 -> count_r_o=0, both pointers 0, empty_o=1 before the next rising edge.
